line_activity_monitor: RTL
==========================

LINE_ACTIVITY_MONITOR -- requirements
Module: line_activity_monitor

Interface
REQ-001 The block SHALL have the parameter HOLD_CYCLES, default 1200000, which sets the LED stretch length in clocks (100 ms at 12 MHz).
REQ-002 The block SHALL have the parameter BREAK_CYCLES, default 12000, which sets the continuous-low time that flags a break (1 ms).
REQ-003 The block SHALL have the parameter HEARTBEAT_HALF, default 6000000, which sets the heartbeat half-period in clocks.
REQ-004 Port clock_12mhz SHALL be an input, 1 bit wide: the single clock for all logic.
REQ-005 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high.
REQ-006 Port lines_in SHALL be an input, 4 bits wide, in the order {uart_uc_cts, rts, uart_uc_tx, rx}, asynchronous to the clock.
REQ-007 Port led_activity SHALL be an output, 4 bits wide, with one stretched-activity indicator per line.
REQ-008 Port led_heartbeat SHALL be an output, 1 bit wide: a free-running square wave.
REQ-009 Port break_detect SHALL be an output, 2 bits wide: break flags for data lines 0 (rx) and 1 (uart_uc_tx).

Function
REQ-010 Each lines_in bit SHALL pass through a 2-flop synchronizer; edge detect compares sync stage 2 with a third history flop.
REQ-011 Edge detection SHALL be suppressed until 3 clocks after reset release (prime counter), so the post-reset level never produces an activity pulse.
REQ-012 Each channel SHALL run a two-state FSM, IDLE and HOLD.
REQ-013 On any edge in IDLE, the FSM SHALL move to HOLD, load the counter with HOLD_CYCLES-1 and assert led_activity on the next clock.
REQ-014 In HOLD, the counter SHALL decrement each clock; when it reaches 0 with no edge, the FSM SHALL return to IDLE and deassert led_activity on the following clock.
REQ-015 An edge in HOLD, including on the same clock the counter is 0, SHALL reload HOLD_CYCLES-1 and stay in HOLD (retrigger wins over expiry).
REQ-016 Total latency from a lines_in change to the led_activity rise SHALL be 4 clocks.
REQ-017 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be handled per REQ-013..015.
REQ-018 Counter widths SHALL be $clog2 of the parameter value, with a minimum of 1 bit; counters never wrap below 0.
REQ-019 The heartbeat counter SHALL count 0..HEARTBEAT_HALF-1 and toggle led_heartbeat on wrap.

Reset
REQ-020 While reset is high, the block SHALL hold: synchronizer and history flops at 1 (UART idle), all FSMs IDLE, all counters 0, led_activity=4'b0000, led_heartbeat=0, break_detect=2'b00, prime counter 0.
REQ-021 An assertion of reset mid-HOLD or mid-break SHALL clear the state immediately (asynchronously), with no residual pulse after release.

Configuration
REQ-022 The break detector SHALL be compiled in only when the macro LINE_MONITOR_BREAK_DETECT_EN is defined.
REQ-023 With the macro defined, for channels 0 and 1 only:
- A saturating low-counter SHALL count clocks while the synchronized line is 0.
- break_detect[n] SHALL assert on the clock the count reaches BREAK_CYCLES.
- break_detect[n] SHALL deassert on the first synchronized high sample.
- The prime window SHALL NOT gate the break detector.
REQ-024 Without the macro, break_detect SHALL be tied to 2'b00, no low-counter logic SHALL be present, and the port list SHALL stay unchanged.

Structure
REQ-025 The package line_monitor_pkg SHALL hold the channel index constants (CH_RX=0, CH_UC_TX=1, CH_RTS=2, CH_UC_CTS=3), the FSM state enum {IDLE, HOLD} and the sync depth constant (2).
REQ-026 The per-channel synchronizer, edge detect and FSM SHALL be one sub-module, activity_stretcher, instantiated 4 times by generate.

Verification (HOLD_CYCLES=8, BREAK_CYCLES=5, HEARTBEAT_HALF=4)
REQ-027 Assert reset with lines_in=4'b0000, release it, then hold for 20 clocks -> led_activity stays 0000 and break_detect[1:0] rises at release+7 (macro on).
REQ-028 Toggle lines_in[2] once at cycle T -> led_activity[2] rises at T+4, is high for exactly 8 clocks, and the other bits stay 0.
REQ-029 Toggle lines_in[0] at T and at T+8 -> led_activity[0] is high continuously from T+4 to T+19, with no gap at the expiry/retrigger collision.
REQ-030 Drive lines_in[1] low for 6 clocks, then high -> break_detect[1] pulses high for 1 clock (macro on); break_detect stays 00 with the macro off.
REQ-031 Free-run for 16 clocks after reset -> led_heartbeat toggles every 4 clocks, starting from 0.
REQ-032 Assert reset during a HOLD of channel 3 -> led_activity[3] drops within the same cycle and stays 0 after release.

Source files
------------

// File: rtl/line_monitor_pkg.sv
// Shared definitions for the line activity monitor: channel indices,
// per-channel FSM states, synchronizer depth and a counter-width helper.
package line_monitor_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CH_RX      = 0;
    localparam int unsigned CH_UC_TX   = 1;
    localparam int unsigned CH_RTS     = 2;
    localparam int unsigned CH_UC_CTS  = 3;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bits needed to hold 0..v-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage : line_monitor_pkg

// File: rtl/line_activity_monitor_stretcher.sv
// One monitored line: 2-flop synchronizer, edge detect against a history
// flop, and a retriggerable stretch FSM driving a registered LED output.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no recent edge, LED off
//   HOLD  | edge seen within the last HOLD_CYCLES clocks, LED on (1 clk later)
module activity_stretcher
    import line_monitor_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1200000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    input  logic prime_done_i,
    output logic line_sync_o,
    output logic led_o
);

    localparam int unsigned CW     = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  hist_q;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  led_q;
    logic                  edge_det;

    // Resynchronize the line; reset to the UART idle level so release is quiet.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], line_i};
            hist_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign line_sync_o = sync_q[SYNC_DEPTH-1];

    // The prime window masks the edge caused by the line level differing
    // from the reset value of the synchronizer.
    assign edge_det = prime_done_i && (sync_q[SYNC_DEPTH-1] != hist_q);

    // Next state: an edge always (re)loads the timer, even on the expiry clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d = HOLD;
                    cnt_d   = RELOAD;
                end
            end
            HOLD: begin
                if (edge_det) begin
                    cnt_d = RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and down-counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // LED follows the state one clock later, giving 4 clocks input-to-LED.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_q <= 1'b0;
        end else begin
            led_q <= (state_q == HOLD);
        end
    end

    assign led_o = led_q;

endmodule : activity_stretcher

// File: rtl/line_activity_monitor.sv
// Line activity monitor: four stretched activity LEDs, a heartbeat square
// wave and, when LINE_MONITOR_BREAK_DETECT_EN is defined, break detection on
// the two data lines (rx, uart_uc_tx). Without the macro break_detect is 0.
module line_activity_monitor
    import line_monitor_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 1200000,
    parameter int unsigned BREAK_CYCLES   = 12000,
    parameter int unsigned HEARTBEAT_HALF = 6000000
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic [3:0]  lines_in,
    output logic [3:0]  led_activity,
    output logic        led_heartbeat,
    output logic [1:0]  break_detect
);

    localparam int unsigned HW = cnt_width(HEARTBEAT_HALF);
    localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_HALF - 1);

    logic [1:0]        prime_q, prime_d;
    logic              prime_done;
    logic [NUM_CH-1:0] line_sync;
    logic [HW-1:0]     hb_cnt_q, hb_cnt_d;
    logic              hb_q, hb_d;

    // Prime counter: saturates at 3, enabling edge detection 3 clocks after release.
    always_comb begin
        prime_d = prime_q;
        if (prime_q != 2'd3) begin
            prime_d = prime_q + 2'd1;
        end
    end

    // Prime counter register.
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            prime_q <= 2'd0;
        end else begin
            prime_q <= prime_d;
        end
    end

    assign prime_done = (prime_q == 2'd3);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        activity_stretcher #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_stretch (
            .clk_i        (clock_12mhz),
            .rst_i        (reset),
            .line_i       (lines_in[ch]),
            .prime_done_i (prime_done),
            .line_sync_o  (line_sync[ch]),
            .led_o        (led_activity[ch])
        );
    end

    // Heartbeat: count 0..HEARTBEAT_HALF-1, toggle the output on wrap.
    always_comb begin
        hb_cnt_d = hb_cnt_q + 1'b1;
        hb_d     = hb_q;
        if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
    end

    // Heartbeat registers.
    always_ff @(posedge clock_12mhz or posedge reset) begin
        if (reset) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign led_heartbeat = hb_q;

    // Control lines never feed the break detector.
    logic unused_ctrl_sync;
    assign unused_ctrl_sync = ^line_sync[CH_UC_CTS:CH_RTS];

`ifdef LINE_MONITOR_BREAK_DETECT_EN
    localparam int unsigned BW = cnt_width(BREAK_CYCLES);
    localparam logic [BW-1:0] BRK_LAST = BW'(BREAK_CYCLES - 1);

    for (genvar n = CH_RX; n <= CH_UC_TX; n++) begin : g_break
        logic [BW-1:0] low_cnt_q, low_cnt_d;
        logic          brk_q, brk_d;

        // Low counter saturates at BREAK_CYCLES-1; the flag sets on the
        // BREAK_CYCLES-th consecutive low clock and stays until the line rises.
        always_comb begin
            low_cnt_d = '0;
            brk_d     = 1'b0;
            if (!line_sync[n]) begin
                brk_d     = (low_cnt_q == BRK_LAST);
                low_cnt_d = (low_cnt_q == BRK_LAST) ? low_cnt_q : low_cnt_q + 1'b1;
            end
        end

        // Low counter and break flag registers; no prime gating here.
        always_ff @(posedge clock_12mhz or posedge reset) begin
            if (reset) begin
                low_cnt_q <= '0;
                brk_q     <= 1'b0;
            end else begin
                low_cnt_q <= low_cnt_d;
                brk_q     <= brk_d;
            end
        end

        // Drop on the very first synchronized high sample, not a clock later.
        assign break_detect[n] = brk_q & ~line_sync[n];
    end
`else
    logic       unused_data_sync;
    logic [31:0] unused_break_cycles;
    assign unused_data_sync    = ^line_sync[CH_UC_TX:CH_RX];
    assign unused_break_cycles = BREAK_CYCLES;
    assign break_detect        = 2'b00;
`endif

endmodule : line_activity_monitor
